// File: rtl/audio_pkg.sv
// Shared definitions for the I2S ADC capture block.
//   AUDIO_WORD_W     : width of the packed {left, right} word read by the PIO
//   CHAN_HALF_W      : width of each channel half of that word
//   SAMPLE_W_DEFAULT : default number of bits captured per channel
//   cap_state_t      : capture state machine encoding
//   msb_align()      : left-justify a narrow sample inside its 16-bit half
package audio_pkg;

  localparam int AUDIO_WORD_W     = 32;
  localparam int CHAN_HALF_W      = 16;
  localparam int SAMPLE_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } cap_state_t;

  // Narrow samples sit in the top bits of their half; the freed LSBs are zero.
  function automatic logic [CHAN_HALF_W-1:0] msb_align(
    input logic [CHAN_HALF_W-1:0] v,
    input int                     w
  );
    return v << (CHAN_HALF_W - w);
  endfunction

endpackage

// File: rtl/audio_i2s_capture_if.sv
// Output bus of the capture block towards the audio input PIO.
//   audio_sample  : {left, right}, each channel MSB-aligned in 16 bits
//   sample_strobe : one-cycle pulse on every update of audio_sample
//   frame_err     : sticky short/aborted-channel flag
//   frame_count   : committed frames, wraps modulo 2^CNT_W
// Modports: master = capture block (drives), slave = consumer (reads).
interface audio_i2s_capture_if
  import audio_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [AUDIO_WORD_W-1:0] audio_sample;
  logic                    sample_strobe;
  logic                    frame_err;
  logic [CNT_W-1:0]        frame_count;

  modport master (
    output audio_sample,
    output sample_strobe,
    output frame_err,
    output frame_count
  );

  modport slave (
    input audio_sample,
    input sample_strobe,
    input frame_err,
    input frame_count
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Brings one asynchronous codec pin into the clk domain.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input pin
//   hist_en    : advance the history flop this cycle
//   sync       : 2-FF synchronised copy of d
//   rise, fall : sync differs from history (0->1 / 1->0)
// With hist_en tied high, rise/fall are single-cycle edge pulses. With
// hist_en driven by a BCLK rise, rise/fall compare against the value seen at
// the previous BCLK rise, so a change launched on the BCLK falling edge is
// still visible when the next rising edge is processed.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  input  logic hist_en,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic hist;

  // NOTE: non-blocking assignments make every flop take its pre-edge value;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      if (hist_en) hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/audio_i2s_capture.sv
// I2S ADC capture: deserialises BCLK/ADCLRCK/ADCDAT into one packed stereo
// word per frame and commits it atomically once both channels are complete.
//   clk, reset  : system clock (>= 4x BCLK), synchronous active-high reset
//   enable      : low forces IDLE, drops any partial frame, holds outputs
//   aud_bclk    : codec bit clock (asynchronous)
//   aud_adclrck : codec LR clock, low = left, high = right (asynchronous)
//   aud_adcdat  : codec serial data, MSB first after a one-slot delay
//   cap_if      : audio_sample / sample_strobe / frame_err / frame_count
module audio_i2s_capture
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                aud_bclk,
  input  logic                aud_adclrck,
  input  logic                aud_adcdat,
  audio_i2s_capture_if.master cap_if
);

  // bit_cnt saturates at SAMPLE_W+1: a channel is complete only once it has
  // seen that many BCLK rises after the slot-0 edge rise.
  localparam int              BC_W       = $clog2(SAMPLE_W + 2);
  localparam logic [BC_W-1:0] BIT_SAT    = BC_W'(SAMPLE_W + 1);
  localparam logic [BC_W-1:0] DATA_SLOTS = BC_W'(SAMPLE_W);

  logic bclk_sync, bclk_rise, bclk_fall;
  logic lrck_sync, lrck_rise, lrck_fall;
  logic dat_sync, dat_rise, dat_fall;

  sync_edge_detect u_bclk_sync (
    .clk     (clk),
    .reset   (reset),
    .d       (aud_bclk),
    .hist_en (1'b1),
    .sync    (bclk_sync),
    .rise    (bclk_rise),
    .fall    (bclk_fall)
  );

  // LRCK history only advances on BCLK rises, so its rise/fall mean
  // "LRCK changed since the previous bit slot".
  sync_edge_detect u_lrck_sync (
    .clk     (clk),
    .reset   (reset),
    .d       (aud_adclrck),
    .hist_en (bclk_rise),
    .sync    (lrck_sync),
    .rise    (lrck_rise),
    .fall    (lrck_fall)
  );

  sync_edge_detect u_dat_sync (
    .clk     (clk),
    .reset   (reset),
    .d       (aud_adcdat),
    .hist_en (1'b1),
    .sync    (dat_sync),
    .rise    (dat_rise),
    .fall    (dat_fall)
  );

  // Synchroniser outputs this block has no use for.
  logic unused_sync_outs;
  assign unused_sync_outs = ^{bclk_sync, bclk_fall, lrck_sync, dat_rise, dat_fall};

  cap_state_t              state;
  logic [BC_W-1:0]         bit_cnt;
  logic [SAMPLE_W-1:0]     left_shift;
  logic [SAMPLE_W-1:0]     right_shift;
  logic [SAMPLE_W-1:0]     left_hold;
  logic                    hold_valid;
  logic [AUDIO_WORD_W-1:0] audio_sample_q;
  logic                    strobe_q;
  logic                    err_q;
  logic [CNT_W-1:0]        count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      left_shift     <= '0;
      right_shift    <= '0;
      left_hold      <= '0;
      hold_valid     <= 1'b0;
      audio_sample_q <= '0;
      strobe_q       <= 1'b0;
      err_q          <= 1'b0;
      count_q        <= '0;
    end else begin
      // NOTE: default low, overridden only in the commit cycle, so the
      // strobe can never stretch beyond one clk.
      strobe_q <= 1'b0;

      if (!enable) begin
        state      <= IDLE;
        hold_valid <= 1'b0;
      end else if (bclk_rise) begin
        case (state)
          IDLE: begin
            if (lrck_fall) begin
              state   <= LEFT;
              bit_cnt <= '0;
            end
          end

          LEFT: begin
            if (lrck_rise) begin
              // The edge rise is slot 0 of the right channel.
              bit_cnt <= '0;
              if (bit_cnt >= BIT_SAT) begin
                left_hold  <= left_shift;
                hold_valid <= 1'b1;
                state      <= RIGHT;
              end else begin
                err_q      <= 1'b1;
                hold_valid <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              // This rise is slot bit_cnt+1; only slots 1..SAMPLE_W carry data.
              if (bit_cnt < DATA_SLOTS) left_shift <= {left_shift[SAMPLE_W-2:0], dat_sync};
              if (bit_cnt < BIT_SAT) bit_cnt <= bit_cnt + BC_W'(1);
            end
          end

          RIGHT: begin
            if (lrck_fall) begin
              bit_cnt    <= '0;
              hold_valid <= 1'b0;
              if (bit_cnt >= BIT_SAT) begin
                state <= LEFT;
                if (hold_valid) begin
                  audio_sample_q <= {msb_align(CHAN_HALF_W'(left_hold), SAMPLE_W),
                                     msb_align(CHAN_HALF_W'(right_shift), SAMPLE_W)};
                  strobe_q       <= 1'b1;
                  count_q        <= count_q + CNT_W'(1);
                end
              end else begin
                err_q <= 1'b1;
                state <= IDLE;
              end
            end else begin
              if (bit_cnt < DATA_SLOTS) right_shift <= {right_shift[SAMPLE_W-2:0], dat_sync};
              if (bit_cnt < BIT_SAT) bit_cnt <= bit_cnt + BC_W'(1);
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign cap_if.audio_sample  = audio_sample_q;
  assign cap_if.sample_strobe = strobe_q;
  assign cap_if.frame_err     = err_q;
  assign cap_if.frame_count   = count_q;

endmodule
